// File: rtl/i2c_slave_byte_ctrl_pkg.sv
// Shared state encodings and reset constants for the I2C target controller.
package i2c_slave_byte_ctrl_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ADDR_ACK = 3'd2,
        RX_BYTE  = 3'd3,
        RX_ACK   = 3'd4,
        TX_BYTE  = 3'd5,
        TX_ACK   = 3'd6,
        SKIP     = 3'd7
    } state_t;

    localparam logic [2:0] CNT_RST  = 3'd7;
    localparam logic       BUS_IDLE = 1'b1;

    function automatic logic addr_hit(input logic [7:0] b, input logic [6:0] a);
        return b[7:1] == a;
    endfunction

endpackage

// File: rtl/i2c_slave_bus_sync.sv
// SCL/SDA synchronizers with registered SCL edge and START/STOP pulses.
module i2c_slave_bus_sync
    import i2c_slave_byte_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic Clk,
    input  logic Rst,
    input  logic Scl_i,
    input  logic Sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic bus_start,
    output logic bus_stop,
    output logic sda_s
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_q;
    logic                   sda_q;
    logic                   scl_c;
    logic                   sda_c;

    assign scl_c = scl_sync[SYNC_STAGES-1];
    assign sda_c = sda_sync[SYNC_STAGES-1];
    assign sda_s = sda_q;

    // sda_s is the previous sample, so it lines up with the registered pulses
    always_ff @(posedge Clk) begin
        if (Rst) begin
            scl_sync  <= {SYNC_STAGES{BUS_IDLE}};
            sda_sync  <= {SYNC_STAGES{BUS_IDLE}};
            scl_q     <= BUS_IDLE;
            sda_q     <= BUS_IDLE;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            bus_start <= 1'b0;
            bus_stop  <= 1'b0;
        end else begin
            scl_sync  <= {scl_sync[SYNC_STAGES-2:0], Scl_i};
            sda_sync  <= {sda_sync[SYNC_STAGES-2:0], Sda_i};
            scl_q     <= scl_c;
            sda_q     <= sda_c;
            scl_rise  <= scl_c & ~scl_q;
            scl_fall  <= ~scl_c & scl_q;
            bus_start <= scl_c & scl_q & sda_q & ~sda_c;
            bus_stop  <= scl_c & scl_q & ~sda_q & sda_c;
        end
    end

endmodule

// File: rtl/i2c_slave_byte_ctrl.sv
// Byte-level I2C target. Define I2C_SLAVE_STRETCH_EN to hold SCL low
// after each Tx_req until the host answers with Tx_valid.
module i2c_slave_byte_ctrl
    import i2c_slave_byte_ctrl_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2,
    parameter int         NBITS       = 3
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Scl_i,
    input  logic       Sda_i,
    output logic       Sda_oe,
    output logic       Scl_oe,
    input  logic [7:0] Tx_data,
    input  logic       Tx_valid,
    output logic       Tx_req,
    output logic [7:0] Rx_data,
    output logic       Rx_valid,
    output logic       Mst_ack,
    output logic       Rw,
    output logic       Busy,
    output logic       Addressed
);

    if (NBITS != STATE_W) begin : g_bad_nbits
        $error("NBITS must match the state encoding width");
    end

    logic scl_rise, scl_fall, bus_start, bus_stop, sda_s;

    i2c_slave_bus_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .Clk      (Clk),
        .Rst      (Rst),
        .Scl_i    (Scl_i),
        .Sda_i    (Sda_i),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .bus_start(bus_start),
        .bus_stop (bus_stop),
        .sda_s    (sda_s)
    );

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] sh_q, sh_d;
    logic [7:0] rxd_q, rxd_d;
    logic       oe_q, oe_d;
    logic       pend_q, pend_d;
    logic       rxv_q, rxv_d;
    logic       txr_q, txr_d;
    logic       mack_q, mack_d;
    logic       rw_q, rw_d;
    logic       busy_q, busy_d;
    logic       adr_q, adr_d;
    logic       rel_q, rel_d;
    logic [7:0] tx_src;

`ifdef I2C_SLAVE_STRETCH_EN
    logic       sclo_q, sclo_d;
    logic       arm_q, arm_d;
    logic       srel_q, srel_d;
    logic [7:0] buf_q, buf_d;

    assign tx_src = buf_q;
    assign Scl_oe = sclo_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            sclo_q <= 1'b0;
            arm_q  <= 1'b0;
            srel_q <= 1'b0;
            buf_q  <= 8'h00;
        end else begin
            sclo_q <= sclo_d;
            arm_q  <= arm_d;
            srel_q <= srel_d;
            buf_q  <= buf_d;
        end
    end
`else
    logic unused_tx_valid;

    assign unused_tx_valid = Tx_valid;
    assign tx_src          = Tx_data;
    assign Scl_oe          = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            cnt_q   <= CNT_RST;
            sh_q    <= 8'h00;
            rxd_q   <= 8'h00;
            oe_q    <= 1'b0;
            pend_q  <= 1'b0;
            rxv_q   <= 1'b0;
            txr_q   <= 1'b0;
            mack_q  <= 1'b0;
            rw_q    <= 1'b0;
            busy_q  <= 1'b0;
            adr_q   <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            rxd_q   <= rxd_d;
            oe_q    <= oe_d;
            pend_q  <= pend_d;
            rxv_q   <= rxv_d;
            txr_q   <= txr_d;
            mack_q  <= mack_d;
            rw_q    <= rw_d;
            busy_q  <= busy_d;
            adr_q   <= adr_d;
            rel_q   <= rel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        rxd_d   = rxd_q;
        oe_d    = oe_q;
        pend_d  = 1'b0;
        rxv_d   = pend_q;
        txr_d   = 1'b0;
        mack_d  = mack_q;
        rw_d    = rw_q;
        busy_d  = busy_q;
        adr_d   = adr_q;
        rel_d   = rel_q;
`ifdef I2C_SLAVE_STRETCH_EN
        sclo_d  = sclo_q;
        arm_d   = arm_q;
        srel_d  = 1'b0;
        buf_d   = buf_q;
`endif
        if (bus_stop) begin
            state_d = IDLE;
            cnt_d   = CNT_RST;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
            adr_d   = 1'b0;
            rel_d   = 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
            sclo_d  = 1'b0;
            arm_d   = 1'b0;
`endif
        end else if (bus_start) begin
            state_d = ADDR;
            cnt_d   = CNT_RST;
            oe_d    = 1'b0;
            busy_d  = 1'b1;
            adr_d   = 1'b0;
            rel_d   = 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
            sclo_d  = 1'b0;
            arm_d   = 1'b0;
        end else if (sclo_q) begin
            // SCL is held low here, so only the host handshake can progress
            if (srel_q) begin
                sclo_d = 1'b0;
            end else if (Tx_valid) begin
                buf_d  = Tx_data;
                srel_d = 1'b1;
                if (state_q == TX_ACK && rel_q) begin
                    state_d = TX_BYTE;
                    cnt_d   = CNT_RST;
                    sh_d    = Tx_data;
                    oe_d    = ~Tx_data[7];
                    rel_d   = 1'b0;
                end
            end
`endif
        end else begin
            unique case (state_q)
                IDLE: ;
                ADDR: begin
                    if (scl_rise) begin
                        sh_d = {sh_q[6:0], sda_s};
                        if (cnt_q == 3'd0) begin
                            rw_d = sda_s;
                            if (addr_hit(sh_d, SLAVE_ADDR)) begin
                                state_d = ADDR_ACK;
                                adr_d   = 1'b1;
                                txr_d   = sda_s;
                            end else begin
                                state_d = SKIP;
                            end
                        end else begin
                            cnt_d = cnt_q - 3'd1;
                        end
                    end
                end
                ADDR_ACK: begin
                    // oe_q low: ACK clock not started yet
                    if (scl_fall) begin
                        if (!oe_q) begin
                            oe_d = 1'b1;
                        end else if (rw_q) begin
                            state_d = TX_BYTE;
                            cnt_d   = CNT_RST;
                            sh_d    = tx_src;
                            oe_d    = ~tx_src[7];
                        end else begin
                            state_d = RX_BYTE;
                            cnt_d   = CNT_RST;
                            oe_d    = 1'b0;
                        end
                    end
                end
                RX_BYTE: begin
                    if (scl_rise) begin
                        sh_d = {sh_q[6:0], sda_s};
                        if (cnt_q == 3'd0) begin
                            rxd_d   = sh_d;
                            pend_d  = 1'b1;
                            state_d = RX_ACK;
                        end else begin
                            cnt_d = cnt_q - 3'd1;
                        end
                    end
                end
                RX_ACK: begin
                    if (scl_fall) begin
                        if (!oe_q) begin
                            oe_d = 1'b1;
                        end else begin
                            oe_d    = 1'b0;
                            state_d = RX_BYTE;
                            cnt_d   = CNT_RST;
                        end
                    end
                end
                TX_BYTE: begin
                    if (scl_fall) begin
                        if (cnt_q == 3'd0) begin
                            oe_d    = 1'b0;
                            state_d = TX_ACK;
                        end else begin
                            cnt_d = cnt_q - 3'd1;
                            oe_d  = ~sh_q[cnt_d];
                        end
                    end
                end
                TX_ACK: begin
                    if (scl_rise && !rel_q) begin
                        mack_d = sda_s;
                        if (sda_s) begin
                            state_d = SKIP;
                        end else begin
                            txr_d = 1'b1;
                            rel_d = 1'b1;
                        end
                    end
`ifndef I2C_SLAVE_STRETCH_EN
                    if (scl_fall && rel_q) begin
                        state_d = TX_BYTE;
                        cnt_d   = CNT_RST;
                        sh_d    = Tx_data;
                        oe_d    = ~Tx_data[7];
                        rel_d   = 1'b0;
                    end
`endif
                end
                SKIP: ;
            endcase
`ifdef I2C_SLAVE_STRETCH_EN
            if (arm_q && scl_fall) begin
                sclo_d = 1'b1;
                arm_d  = 1'b0;
            end
            if (txr_d) begin
                arm_d = 1'b1;
            end
`endif
        end
    end

    assign Sda_oe    = oe_q;
    assign Tx_req    = txr_q;
    assign Rx_data   = rxd_q;
    assign Rx_valid  = rxv_q;
    assign Mst_ack   = mack_q;
    assign Rw        = rw_q;
    assign Busy      = busy_q;
    assign Addressed = adr_q;

endmodule

// File: tb/tb_i2c_slave_byte_ctrl.sv
// Bench for i2c_slave_byte_ctrl: bus master model, host model and scoreboard.
module tb_i2c_slave_byte_ctrl;

    localparam logic [6:0] SADDR = 7'h50;
    localparam int         Q     = 6;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       scl_bus, sda_bus;
    logic       Sda_oe, Scl_oe, Tx_req, Rx_valid, Mst_ack, Rw, Busy, Addressed;
    logic [7:0] Tx_data, Rx_data;
    logic       Tx_valid;

    int n_vec = 0;
    int n_bad = 0;
    bit oe_seen = 0;

    logic [7:0] exp_rx[$];
    logic [7:0] exp_rd[$];
    logic [7:0] obs_rd[$];
    logic [7:0] host_q[$];
    logic       exp_ack[$];
    logic       obs_ack[$];

    assign scl_bus = scl_m & ~Scl_oe;
    assign sda_bus = sda_m & ~Sda_oe;

    i2c_slave_byte_ctrl dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Scl_i    (scl_bus),
        .Sda_i    (sda_bus),
        .Sda_oe   (Sda_oe),
        .Scl_oe   (Scl_oe),
        .Tx_data  (Tx_data),
        .Tx_valid (Tx_valid),
        .Tx_req   (Tx_req),
        .Rx_data  (Rx_data),
        .Rx_valid (Rx_valid),
        .Mst_ack  (Mst_ack),
        .Rw       (Rw),
        .Busy     (Busy),
        .Addressed(Addressed)
    );

    always #5 Clk = ~Clk;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic scl_up();
        int i;
        scl_m = 1'b1;
        i = 0;
        while (!scl_bus && i < 4000) begin
            @(negedge Clk);
            i++;
        end
        if (!scl_bus) begin
            n_vec++;
            n_bad++;
            $display("FAIL scl_release: got SCL low, expected high within 4000 cycles");
        end
    endtask

    task automatic start_c();
        sda_m = 1'b1;
        tick(Q);
        scl_up();
        tick(Q);
        sda_m = 1'b0;
        tick(Q);
        scl_m = 1'b0;
        tick(Q);
    endtask

    task automatic stop_c();
        sda_m = 1'b0;
        tick(Q);
        scl_up();
        tick(Q);
        sda_m = 1'b1;
        tick(2 * Q);
    endtask

    task automatic bit_c(input logic b, output logic r);
        sda_m = b;
        tick(Q);
        scl_up();
        tick(Q);
        r = sda_bus;
        tick(Q);
        scl_m = 1'b0;
        tick(Q);
    endtask

    task automatic byte_wr(input logic [7:0] b);
        logic r;
        for (int i = 7; i >= 0; i--) bit_c(b[i], r);
        bit_c(1'b1, r);
        obs_ack.push_back(r);
    endtask

    task automatic byte_rd(input logic nack);
        logic [7:0] v;
        logic       r;
        for (int i = 7; i >= 0; i--) begin
            bit_c(1'b1, r);
            v[i] = r;
        end
        bit_c(nack, r);
        obs_rd.push_back(v);
    endtask

    // Reference: a target at SADDR ACKs its address and every written byte,
    // returns host bytes in order on reads; anything else sees a released bus.
    task automatic xfer(input logic [6:0] a, input logic r, input int n,
                        input bit do_stop, input logic [31:0] data);
        logic [7:0] db[4];
        bit         hit;
        hit = (a == SADDR);
        for (int i = 0; i < n; i++) db[i] = data[31-8*i -: 8];
        exp_ack.push_back(!hit);
        if (r) begin
            for (int i = 0; i < n; i++) begin
                if (hit) host_q.push_back(db[i]);
                exp_rd.push_back(hit ? db[i] : 8'hFF);
            end
        end
        oe_seen = 0;
        start_c();
        byte_wr({a, r});
        cmp("busy_addr", Busy, 1);
        cmp("addressed", Addressed, hit);
        if (hit) cmp("rw", Rw, r);
        for (int i = 0; i < n; i++) begin
            if (r) begin
                byte_rd(i == n - 1);
            end else begin
                exp_ack.push_back(!hit);
                if (hit) exp_rx.push_back(db[i]);
                byte_wr(db[i]);
            end
        end
        if (r && hit) cmp("mst_ack", Mst_ack, 1);
        if (!hit) cmp("oe_quiet", oe_seen, 0);
        if (do_stop) begin
            stop_c();
            cmp("busy_stop", Busy, 0);
            cmp("addressed_stop", Addressed, 0);
            cmp("sda_oe_stop", Sda_oe, 0);
        end
        cmp("tx_req_served", host_q.size(), 0);
    endtask

    initial forever begin
        @(negedge Clk);
        if (Sda_oe) oe_seen = 1;
    end

    initial forever begin
        @(negedge Clk);
        if (Rx_valid) begin
            if (exp_rx.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL rx_valid: got pulse with %0h, expected none", Rx_data);
            end else begin
                cmp("rx_data", Rx_data, exp_rx.pop_front());
            end
        end
        while (obs_ack.size() > 0) begin
            if (exp_ack.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL ack_slot: got an unexpected ACK slot");
                void'(obs_ack.pop_front());
            end else begin
                cmp("ack_bit", obs_ack.pop_front(), exp_ack.pop_front());
            end
        end
        while (obs_rd.size() > 0) begin
            if (exp_rd.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL rd_byte: got an unexpected read byte");
                void'(obs_rd.pop_front());
            end else begin
                cmp("rd_byte", obs_rd.pop_front(), exp_rd.pop_front());
            end
        end
    end

    initial begin
        logic [7:0] hd;
        Tx_data  = 8'h00;
        Tx_valid = 1'b0;
        forever begin
            @(negedge Clk);
            if (Tx_req) begin
                if (host_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL tx_req: got pulse, expected none");
                end else begin
                    hd = host_q.pop_front();
`ifdef I2C_SLAVE_STRETCH_EN
                    repeat (50) @(negedge Clk);
                    cmp("scl_stretch", Scl_oe, 1);
                    Tx_data  = hd;
                    Tx_valid = 1'b1;
                    @(negedge Clk);
                    Tx_valid = 1'b0;
                    cmp("scl_hold", Scl_oe, 1);
                    @(negedge Clk);
                    cmp("scl_release", Scl_oe, 0);
`else
                    Tx_data = hd;
`endif
                end
            end
        end
    end

    initial begin
        #800us;
        $display("FAIL watchdog: got no finish, expected finish before 800us");
        $fatal(1, "watchdog");
    end

    initial begin
        logic r;
        tick(4);
        cmp("rst_sda_oe", Sda_oe, 0);
        cmp("rst_scl_oe", Scl_oe, 0);
        cmp("rst_busy", Busy, 0);
        cmp("rst_outs", {Tx_req, Rx_valid, Mst_ack, Rw, Addressed}, 0);
        cmp("rst_rx_data", Rx_data, 0);
        Rst = 1'b0;
        tick(4);

        xfer(7'h50, 1'b0, 1, 1, 32'h3C000000);
        xfer(7'h50, 1'b1, 2, 1, 32'h965A0000);
        xfer(7'h51, 1'b0, 1, 1, 32'h11000000);
        xfer(7'h50, 1'b0, 1, 0, 32'h01000000);
        xfer(7'h50, 1'b1, 2, 1, $urandom);

        // reset while the target drives the data ACK
        start_c();
        exp_ack.push_back(1'b0);
        byte_wr(8'hA0);
        exp_rx.push_back(8'hC5);
        for (int i = 7; i >= 0; i--) bit_c(((8'hC5 >> i) & 8'h01) != 0, r);
        cmp("ack_driven", Sda_oe, 1);
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        cmp("rst_release_oe", Sda_oe, 0);
        @(negedge Clk);
        Rst = 1'b0;
        cmp("rst_busy_mid", Busy, 0);
        sda_m = 1'b1;
        tick(Q);
        scl_m = 1'b1;
        tick(2 * Q);

        // STOP in the middle of a data byte
        start_c();
        exp_ack.push_back(1'b0);
        byte_wr(8'hA0);
        for (int i = 0; i < 3; i++) bit_c(1'($urandom), r);
        stop_c();
        cmp("busy_midstop", Busy, 0);
        cmp("addressed_midstop", Addressed, 0);

        for (int t = 0; t < 12; t++) begin
            logic [6:0] a;
            a = ($urandom_range(0, 1) != 0) ? SADDR : 7'($urandom);
            xfer(a, 1'($urandom), $urandom_range(1, 3), 1, $urandom);
        end

        tick(20);
        cmp("rx_drained", exp_rx.size(), 0);
        cmp("ack_drained", exp_ack.size(), 0);
        cmp("rd_drained", exp_rd.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
